spi_slave_rx: RTL and testbench



---
 rtl/spi_slave_rx.sv | 190 +++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_rx
//  Description : SPI slave receiver. Oversamples SCLK/CS/MOSI on clk, supports
//                all four CPOL/CPHA modes, assembles MSB-first words and hands
//                them to the system side with a valid/ack handshake and a
//                sticky overrun flag. Define SPI_SLAVE_RX_MISO_EN to compile in
//                the MISO shift-out path; otherwise miso is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              busy,
  input  logic [DATA_W-1:0] tx_data,
  output logic              miso
);

  localparam int c_CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_mosi_d;
  logic                   r_sample_stb;
  logic [c_CNT_W-1:0]     r_bit_cnt;
  logic [DATA_W-1:0]      r_shift;
  logic [DATA_W-1:0]      r_rx_data;
  logic                   r_rx_valid;
  logic                   r_overrun;
  logic                   w_sclk_s;
  logic                   w_cs_s;
  logic                   w_mosi_s;
  logic                   w_lead;
  logic                   w_trail;
  logic                   w_complete;
  logic [DATA_W-1:0]      w_word;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign w_lead  = (w_sclk_s != r_sclk_d) && (w_sclk_s != cpol);
  assign w_trail = (w_sclk_s != r_sclk_d) && (w_sclk_s == cpol);
  assign w_word  = {r_shift[DATA_W-2:0], r_mosi_d};

  // Equal-depth synchronizers keep MOSI aligned with SCLK; CS resets inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync  <= '0;
      r_cs_sync    <= '1;
      r_mosi_sync  <= '0;
      r_sclk_d     <= 1'b0;
      r_mosi_d     <= 1'b0;
      r_sample_stb <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync  <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d     <= w_sclk_s;
      r_mosi_d     <= w_mosi_s;
      r_sample_stb <= cpha ? w_trail : w_lead;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and word-completion strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_cs_s) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_cs_s) w_state_nxt = S_IDLE;
        else        w_complete  = r_sample_stb && (r_bit_cnt == c_LAST);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Receive shift register and bit counter; a CS rise drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (r_state == S_IDLE || w_cs_s) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (r_sample_stb) begin
      r_shift   <= w_word;
      r_bit_cnt <= w_complete ? '0 : r_bit_cnt + c_CNT_W'(1);
    end
  end

  // Output word, valid handshake (completion beats ack) and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_complete) begin
        r_rx_data  <= w_word;
        r_rx_valid <= 1'b1;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
      if (w_complete && r_rx_valid && !rx_ack) r_overrun <= 1'b1;
      else if (ovr_clr)                        r_overrun <= 1'b0;
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign overrun  = r_overrun;
  assign busy     = ~w_cs_s;

`ifdef SPI_SLAVE_RX_MISO_EN
  logic              r_drive_stb;
  logic [DATA_W-1:0] r_tx_sr;
  logic              r_miso_q;
  logic [DATA_W-1:0] w_tx_src;

  // At a word boundary (counter wrapped) the next word comes from tx_data.
  assign w_tx_src = (r_bit_cnt == '0) ? tx_data : r_tx_sr;

  // Drive-edge strobe, delayed to line up with the sample strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_drive_stb <= 1'b0;
    else        r_drive_stb <= cpha ? w_lead : w_trail;
  end

  // TX shifter: cpha=0 presents the MSB directly and shifts on trailing edges;
  // cpha=1 launches each bit into r_miso_q on leading edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sr  <= '0;
      r_miso_q <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_tx_sr  <= tx_data;
      r_miso_q <= 1'b0;
    end else if (!w_cs_s && r_drive_stb) begin
      if (cpha) begin
        r_miso_q <= w_tx_src[DATA_W-1];
        r_tx_sr  <= {w_tx_src[DATA_W-2:0], 1'b0};
      end else begin
        r_tx_sr  <= (r_bit_cnt == '0) ? tx_data : {r_tx_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign miso = (r_state == S_ACTIVE) ? (cpha ? r_miso_q : r_tx_sr[DATA_W-1]) : 1'b0;
`else
  logic w_unused_tx;
  assign w_unused_tx = ^tx_data;
  assign miso        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_rx
//  Description : Directed, table-driven bench for spi_slave_rx acting as an
//                SPI master in all four modes. MISO expectations follow the
//                SPI_SLAVE_RX_MISO_EN build setting.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx;

  localparam int H = 6;  // clk cycles per SCLK half period
`ifdef SPI_SLAVE_RX_MISO_EN
  localparam logic [7:0] c_EXP_MISO = 8'h96;
`else
  localparam logic [7:0] c_EXP_MISO = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst_n, cpol, cpha, sclk, cs, mosi, rx_ack, ovr_clr;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, busy, miso;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs(cs),
    .mosi(mosi), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .overrun(overrun), .ovr_clr(ovr_clr), .busy(busy), .tx_data(tx_data),
    .miso(miso)
  );

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] tx;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sclk = p;
    wait_clk(8);
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_end();
    wait_clk(H);
    cs = 1'b1;
    wait_clk(8);
  endtask

  // One bit in the current mode; m is MISO as seen at the master's sample edge.
  task automatic spi_bit(input logic b, output logic m);
    if (!cpha) begin
      mosi = b;
      wait_clk(H);
      m    = miso;
      sclk = ~cpol;
      wait_clk(H);
      sclk = cpol;
    end else begin
      sclk = ~cpol;
      mosi = b;
      wait_clk(H);
      m    = miso;
      sclk = cpol;
      wait_clk(H);
    end
  endtask

  task automatic spi_word(input logic [7:0] d, output logic [7:0] m);
    logic mb;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(d[i], mb);
      m[i] = mb;
    end
  endtask

  task automatic frame(input logic [7:0] d, output logic [7:0] m);
    cs_begin();
    spi_word(d, m);
    cs_end();
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
    wait_clk(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] m, m2;
    logic       mb;
    logic [7:0] pat;

    vecs[0] = '{cpol: 1'b0, cpha: 1'b0, tx: 8'hA3, exp_rx: 8'hA3};
    vecs[1] = '{cpol: 1'b0, cpha: 1'b1, tx: 8'hA3, exp_rx: 8'hA3};
    vecs[2] = '{cpol: 1'b1, cpha: 1'b0, tx: 8'h5C, exp_rx: 8'h5C};
    vecs[3] = '{cpol: 1'b1, cpha: 1'b0, tx: 8'hA3, exp_rx: 8'hA3};
    vecs[4] = '{cpol: 1'b1, cpha: 1'b1, tx: 8'hA3, exp_rx: 8'hA3};

    rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    rx_ack = 1'b0; ovr_clr = 1'b0; tx_data = 8'h96;
    wait_clk(3);
    chk("reset rx_data", 32'(rx_data), 32'h00);
    chk("reset rx_valid", 32'(rx_valid), 32'h0);
    chk("reset overrun", 32'(overrun), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset miso", 32'(miso), 32'h0);
    rst_n = 1'b1;
    wait_clk(5);

    // Latency: rx_valid rises 4 clk edges after the 8th sample edge at the pin.
    set_mode(1'b0, 1'b0);
    cs_begin();
    chk("busy in frame", 32'(busy), 32'h1);
    pat = 8'hA3;
    for (int i = 7; i >= 1; i--) spi_bit(pat[i], mb);
    mosi = pat[0];
    wait_clk(H);
    sclk = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("latency valid early", 32'(rx_valid), 32'h0);
    @(posedge clk);
    #1 chk("latency valid on time", 32'(rx_valid), 32'h1);
    @(negedge clk);
    wait_clk(H - 4);
    sclk = 1'b0;
    cs_end();
    chk("latency rx_data", 32'(rx_data), 32'hA3);
    chk("latency overrun", 32'(overrun), 32'h0);
    do_ack();
    chk("latency ack clears", 32'(rx_valid), 32'h0);

    // Mode table.
    for (int v = 0; v < 5; v++) begin
      set_mode(vecs[v].cpol, vecs[v].cpha);
      frame(vecs[v].tx, m);
      chk($sformatf("vec%0d rx_valid", v), 32'(rx_valid), 32'h1);
      chk($sformatf("vec%0d rx_data", v), 32'(rx_data), 32'(vecs[v].exp_rx));
      chk($sformatf("vec%0d overrun", v), 32'(overrun), 32'h0);
      chk($sformatf("vec%0d miso word", v), 32'(m), 32'(c_EXP_MISO));
      do_ack();
      chk($sformatf("vec%0d ack", v), 32'(rx_valid), 32'h0);
    end

    // Back-to-back words without ack: overwrite and overrun, then clear.
    set_mode(1'b1, 1'b1);
    cs_begin();
    spi_word(8'h5C, m);
    spi_word(8'h81, m2);
    cs_end();
    chk("b2b miso word1", 32'(m), 32'(c_EXP_MISO));
    chk("b2b miso word2", 32'(m2), 32'(c_EXP_MISO));
    chk("b2b rx_valid", 32'(rx_valid), 32'h1);
    chk("b2b rx_data", 32'(rx_data), 32'h81);
    chk("b2b overrun", 32'(overrun), 32'h1);
    ovr_clr = 1'b1;
    wait_clk(1);
    ovr_clr = 1'b0;
    chk("b2b ovr_clr", 32'(overrun), 32'h0);
    do_ack();
    chk("b2b ack", 32'(rx_valid), 32'h0);

    // CS raised after 5 bits: partial word dropped, next frame clean.
    set_mode(1'b0, 1'b0);
    cs_begin();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, mb);
    cs_end();
    chk("abort no valid", 32'(rx_valid), 32'h0);
    frame(8'h3C, m);
    chk("abort next valid", 32'(rx_valid), 32'h1);
    chk("abort next data", 32'(rx_data), 32'h3C);
    chk("abort next overrun", 32'(overrun), 32'h0);
    do_ack();

    // Completion and ack in the same clk cycle: valid stays, no overrun.
    frame(8'h11, m);
    cs_begin();
    pat = 8'h22;
    for (int i = 7; i >= 1; i--) spi_bit(pat[i], mb);
    mosi = pat[0];
    wait_clk(H);
    sclk = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    chk("same-cycle ack valid", 32'(rx_valid), 32'h1);
    chk("same-cycle ack overrun", 32'(overrun), 32'h0);
    wait_clk(H - 4);
    sclk = 1'b0;
    cs_end();
    chk("same-cycle ack data", 32'(rx_data), 32'h22);
    do_ack();

    // Reset pulsed mid-word with a word pending.
    frame(8'h55, m);
    cs_begin();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, mb);
    rst_n = 1'b0;
    #1;
    chk("midreset rx_valid", 32'(rx_valid), 32'h0);
    chk("midreset rx_data", 32'(rx_data), 32'h00);
    chk("midreset overrun", 32'(overrun), 32'h0);
    chk("midreset busy", 32'(busy), 32'h0);
    chk("midreset miso", 32'(miso), 32'h0);
    @(negedge clk);
    cs = 1'b1;
    sclk = cpol;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    frame(8'h11, m);
    chk("post-reset valid", 32'(rx_valid), 32'h1);
    chk("post-reset data", 32'(rx_data), 32'h11);
    chk("post-reset miso word", 32'(m), 32'(c_EXP_MISO));
    do_ack();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
